// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   state_e : controller states (IDLE=0, SHIFT=1, DONE=2)
//   clog2() : bit width needed to hold a count of 0..n-1
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Smallest w with 2**w >= n; returns at least 1 so that a counter
    // declared with this width is never zero bits wide.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fa_slice.sv
// fa_slice
// Combinational one-bit full adder.
// Ports:
//   a, b, cin : addend bits and carry-in
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB
// first, using a single fa_slice and a registered carry.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered signed
// overflow output 'ovf'.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low
//   start : request, sampled in IDLE or DONE
//   a, b  : WIDTH-bit operands, captured on the accepting edge
//   cin   : carry-in, captured on the accepting edge
//   busy  : high while bits are being processed
//   done  : one-cycle pulse, sum/cout valid
//   sum   : registered result
//   cout  : registered carry-out of bit WIDTH-1
//   ovf   : (SERIAL_ADDER_OVF_EN only) registered two's-complement overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               bit_sum;
    logic               bit_carry;

    fa_slice u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (bit_sum),
        .cout (bit_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = cin;
                    res_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end else if (state_q == DONE) begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                // New bit enters at the MSB so after WIDTH shifts bit 0 of
                // the operands has landed in bit 0 of the result.
                res_sr_d = {bit_sum, res_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = bit_carry;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {bit_sum, res_sr_q[WIDTH-1:1]};
                    cout_d  = bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB slice.
                    ovf_d   = carry_q ^ bit_carry;
`endif
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Directed self-checking bench for serial_adder (WIDTH=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accepts an operation on the next edge and follows it to its done cycle.
    // Returns 1 time unit after the edge that raises done (i.e. in DONE).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] es, input logic ec, input string tag);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        chk({tag, "_done_low0"}, 32'(done), 32'd0);
        for (int i = 1; i < WIDTH; i++) begin
            step();
            chk({tag, "_busy_hold"}, 32'(busy), 32'd1);
            chk({tag, "_done_early"}, 32'(done), 32'd0);
        end
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        $display("op %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d", tag, ta, tb_v, tc, sum, cout);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Reset held for three edges
        step(); step(); step();
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_done", 32'(done), 32'd0);
        end

        // Basic add
        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "op1");
        step();
        chk("op1_done_1cyc", 32'(done), 32'd0);
        chk("op1_idle_busy", 32'(busy), 32'd0);
        chk("op1_sum_hold", 32'(sum), 32'h10);

        // Carry out, then a back-to-back start issued in the DONE cycle
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "op2");
        run_op(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "op3");
        step();
        chk("op3_done_1cyc", 32'(done), 32'd0);

        // Start mid-SHIFT is ignored
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("op4_busy", 32'(busy), 32'd1);
        for (int i = 1; i < WIDTH; i++) begin
            if (i == 3) begin
                a = 8'hFF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            chk("op4_busy_hold", 32'(busy), 32'd1);
            chk("op4_sum_held_prev", 32'(sum), 32'h00);
        end
        start = 1'b0;
        step();
        chk("op4_done", 32'(done), 32'd1);
        chk("op4_sum",  32'(sum),  32'h07);
        chk("op4_cout", 32'(cout), 32'd0);
        $display("op op4: a=03 b=04 (mid-shift start ignored) -> sum=%h cout=%0d", sum, cout);
        for (int i = 0; i < WIDTH + 2; i++) begin
            step();
            chk("op4_single_done", 32'(done), 32'd0);
            chk("op4_no_restart", 32'(busy), 32'd0);
        end

        // Reset in the middle of an operation
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("op5_busy_pre_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("op5_rst_busy", 32'(busy), 32'd0);
        chk("op5_rst_done", 32'(done), 32'd0);
        chk("op5_rst_sum",  32'(sum),  32'd0);
        chk("op5_rst_cout", 32'(cout), 32'd0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            step();
            chk("op5_no_done", 32'(done), 32'd0);
        end
        $display("op op5: reset mid-shift -> sum=%h cout=%0d", sum, cout);

`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf_rst", 32'(ovf), 32'd0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "ovf1");
        chk("ovf1_ovf", 32'(ovf), 32'd1);
        run_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, "ovf2");
        chk("ovf2_ovf", 32'(ovf), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
